// File: rtl/mont_exp_ctrl.sv
// rtl/mont_exp_ctrl.sv - left-to-right square-and-multiply sequencer for a Montgomery multiplier
// Operands to the multiplier come from registers only, so they stay still for the whole multiply.
module mont_exp_ctrl #(
  parameter int N  = 1024,
  parameter int EW = 1024,
  parameter int LW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  x_mont,
  input  logic [N-1:0]  r_mod_m,
  input  logic [EW-1:0] exponent,
  input  logic [LW-1:0] exp_len,
  input  logic [N-1:0]  modulus,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic          mult_start,
  output logic [N-1:0]  mult_a,
  output logic [N-1:0]  mult_b,
  output logic [N-1:0]  mult_m,
  input  logic [N-1:0]  mult_result,
  input  logic          mult_done
);

  typedef enum logic [3:0] {
    IDLE, LOAD, SQR_ISSUE, SQR_WAIT, MUL_ISSUE, MUL_WAIT,
    NEXT, POST_ISSUE, POST_WAIT, DONE
  } state_t;

  typedef enum logic [1:0] {B_A, B_X, B_ONE} bsel_t;

  state_t        state;
  bsel_t         b_sel;
  logic [N-1:0]  a_reg, x_reg, m_reg;
  logic [EW-1:0] e_reg;
  logic [LW-1:0] idx;
  logic [LW-1:0] idx_m1;
  logic          e_bit;

  assign idx_m1 = idx - LW'(1);
  assign e_bit  = |(e_reg & (EW'(1) << idx_m1));

  assign mult_a = a_reg;
  assign mult_m = m_reg;

  always_comb begin
    mult_b = a_reg;
    case (b_sel)
      B_X:     mult_b = x_reg;
      B_ONE:   mult_b = N'(1);
      default: mult_b = a_reg;
    endcase
  end

  // mult_start and b_sel are set on the edge that enters an ISSUE state,
  // so the pulse lines up exactly with the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      b_sel      <= B_A;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      mult_start <= 1'b0;
      a_reg      <= '0;
      x_reg      <= '0;
      m_reg      <= '0;
      e_reg      <= '0;
      idx        <= '0;
    end else begin
      mult_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_reg <= x_mont;
            a_reg <= r_mod_m;
            e_reg <= exponent;
            m_reg <= modulus;
            idx   <= exp_len;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          mult_start <= 1'b1;
          if (idx == '0) begin
            b_sel <= B_ONE;
            state <= POST_ISSUE;
          end else begin
            b_sel <= B_A;
            state <= SQR_ISSUE;
          end
        end
        SQR_ISSUE: state <= SQR_WAIT;
        SQR_WAIT: begin
          if (mult_done) begin
            a_reg <= mult_result;
            if (e_bit) begin
              mult_start <= 1'b1;
              b_sel      <= B_X;
              state      <= MUL_ISSUE;
            end else begin
              state <= NEXT;
            end
          end
        end
        MUL_ISSUE: state <= MUL_WAIT;
        MUL_WAIT: begin
          if (mult_done) begin
            a_reg <= mult_result;
            state <= NEXT;
          end
        end
        NEXT: begin
          idx        <= idx_m1;
          mult_start <= 1'b1;
          if (idx_m1 == '0) begin
            b_sel <= B_ONE;
            state <= POST_ISSUE;
          end else begin
            b_sel <= B_A;
            state <= SQR_ISSUE;
          end
        end
        POST_ISSUE: state <= POST_WAIT;
        POST_WAIT: begin
          if (mult_done) begin
            result <= mult_result;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// tb/tb_mont_exp_ctrl.sv - randomized bench for mont_exp_ctrl with a behavioural Montgomery multiplier
// Expected operands come from the ladder written in plain modular arithmetic; results from ordinary pow.
module tb_mont_exp_ctrl;
  localparam int N = 16, EW = 16, LW = 5;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [N-1:0]  x_mont = '0, r_mod_m = '0, modulus = '0;
  logic [EW-1:0] exponent = '0;
  logic [LW-1:0] exp_len = '0;
  logic          busy, done, mult_start;
  logic [N-1:0]  result, mult_a, mult_b, mult_m;
  logic [N-1:0]  mult_result = '0;
  logic          mult_done = 1'b0;

  mont_exp_ctrl #(.N(N), .EW(EW), .LW(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .x_mont(x_mont), .r_mod_m(r_mod_m),
    .exponent(exponent), .exp_len(exp_len), .modulus(modulus), .busy(busy), .done(done),
    .result(result), .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_m(mult_m), .mult_result(mult_result), .mult_done(mult_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint modinv(input longint a, input longint m);
    longint r0 = m, r1 = a % m, s0 = 0, s1 = 1, q, t;
    while (r1 != 0) begin
      q = r0 / r1;
      t = r0 - q * r1; r0 = r1; r1 = t;
      t = s0 - q * s1; s0 = s1; s1 = t;
    end
    return ((s0 % m) + m) % m;
  endfunction

  // a*b*R^-1 mod m, with R = 2^N
  function automatic longint mont(input longint a, input longint b, input longint m);
    return (((a * b) % m) * modinv(65536 % m, m)) % m;
  endfunction

  function automatic longint powmod(input longint x, input longint e, input int t, input longint m);
    longint r = 1 % m;
    for (int i = t - 1; i >= 0; i--) begin
      r = (r * r) % m;
      if (((e >> i) & 1) != 0) r = (r * x) % m;
    end
    return r;
  endfunction

  longint ea[64], eb[64];
  int     en = 0;
  longint em = 0, eres = 0;

  // multiplier stand-in
  int     lat_fixed = 7;
  bit     dbl_mode = 0;
  int     spur_req = 0, spur_ack = 0;
  bit     pend = 0, dbl_pend = 0, done_real = 0;
  int     cnt = 0;
  longint pa = 0, pb = 0, pm = 1;

  always @(negedge clk) begin
    mult_done = 1'b0;
    done_real = 1'b0;
    if (spur_ack != spur_req) begin
      mult_done = 1'b1; mult_result = N'($urandom); spur_ack++;
    end else if (dbl_pend) begin
      mult_done = 1'b1; mult_result = N'($urandom); dbl_pend = 0;
    end else if (pend) begin
      cnt--;
      if (cnt <= 0) begin
        mult_done = 1'b1; done_real = 1'b1;
        mult_result = N'(mont(pa, pb, pm));
        pend = 0; dbl_pend = dbl_mode;
      end
    end
    if (mult_start) begin
      pend = 1;
      pa = longint'(mult_a); pb = longint'(mult_b); pm = longint'(mult_m);
      cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 40));
    end
  end

  // compare process
  int op_idx = 0, done_cnt = 0, last_count = 0;
  bit in_op = 0, prev_busy = 0, prev_done = 0;
  logic [N-1:0] ha = '0, hb = '0;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      in_op = 0; prev_busy = 0; prev_done = 0;
    end else begin
      if (busy && !prev_busy) op_idx = 0;
      if (mult_done && done_real) in_op = 0;
      if (mult_start) begin
        chk("extra_start", longint'(op_idx < en), 1);
        if (op_idx < en) begin
          chk("mult_a", longint'(mult_a), ea[op_idx]);
          chk("mult_b", longint'(mult_b), eb[op_idx]);
        end
        chk("mult_m", longint'(mult_m), em);
        ha = mult_a; hb = mult_b; in_op = 1; op_idx++;
      end else if (in_op) begin
        chk("hold_a", longint'(mult_a), longint'(ha));
        chk("hold_b", longint'(mult_b), longint'(hb));
      end
      if (done) begin
        chk("result", longint'(result), eres);
        chk("mult_count", longint'(op_idx), longint'(en));
        chk("busy_at_done", longint'(busy), 0);
        chk("done_pulse", longint'(prev_done), 0);
        last_count = op_idx;
        done_cnt++;
      end
      prev_busy = busy; prev_done = done;
    end
  end

  task automatic launch(input longint x, input longint e, input int t, input longint m);
    longint r, xm, acc;
    int k = 0;
    r = 65536 % m; xm = (x * 65536) % m; acc = r;
    for (int i = t - 1; i >= 0; i--) begin
      ea[k] = acc; eb[k] = acc; k++; acc = mont(acc, acc, m);
      if (((e >> i) & 1) != 0) begin
        ea[k] = acc; eb[k] = xm; k++; acc = mont(acc, xm, m);
      end
    end
    ea[k] = acc; eb[k] = 1; k++;
    en = k; em = m; eres = powmod(x, e, t, m);
    @(negedge clk);
    x_mont = N'(xm); r_mod_m = N'(r); exponent = EW'(e); exp_len = LW'(t); modulus = N'(m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt, cyc = 0;
    while (done_cnt == d0 && cyc < 5000) begin @(negedge clk); cyc++; end
    chk(name, longint'(done_cnt - d0), 1);
  endtask

  task automatic wait_ops(input int n);
    int cyc = 0;
    while (op_idx < n && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("reach_op", longint'(op_idx >= n), 1);
  endtask

  function automatic longint rand_mod();
    return longint'($urandom_range(3, 32767) | 1);
  endfunction

  initial begin
    longint m, x, e, r0;
    int d0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_result", longint'(result), 0);
    chk("rst_mult_start", longint'(mult_start), 0);
    @(negedge clk); reset = 1'b0;

    // 5^3 mod 13 = 8, five multiplications
    lat_fixed = 7;
    launch(5, 3, 2, 13);
    chk("pin_model_res", eres, 8);
    wait_done("done_basic");
    chk("pin_res_8", longint'(result), 8);
    chk("pin_count_5", longint'(last_count), 5);

    // empty exponent: only the conversion out of Montgomery form
    launch(5, 0, 0, 13);
    wait_done("done_t0");
    chk("pin_res_1", longint'(result), 1);
    chk("pin_count_1", longint'(last_count), 1);

    // t=8, e=0xA5, random latency per op
    lat_fixed = 0;
    m = rand_mod(); x = longint'($urandom_range(0, 32767)) % m;
    launch(x, 'hA5, 8, m);
    wait_done("done_a5");
    chk("pin_count_a5", longint'(last_count), 13);

    // a second start during SQR_WAIT is ignored
    lat_fixed = 12;
    m = rand_mod(); x = longint'($urandom_range(0, 32767)) % m;
    launch(x, longint'($urandom_range(0, 255)), 8, m);
    wait_ops(1);
    @(negedge clk);
    x_mont = N'($urandom); exponent = EW'($urandom); exp_len = LW'(3); modulus = 16'd101;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("done_restart_ignored");

    // reset during the third wait abandons the operation
    lat_fixed = 10;
    m = rand_mod(); x = longint'($urandom_range(0, 32767)) % m;
    launch(x, longint'($urandom_range(0, 255)), 8, m);
    wait_ops(3);
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_mult_start", longint'(mult_start), 0);
    chk("midrst_done", longint'(done), 0);
    @(negedge clk); reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("abandoned_no_done", longint'(done_cnt - d0), 0);
    chk("abandoned_idle", longint'(busy), 0);
    lat_fixed = 0;
    m = rand_mod(); x = longint'($urandom_range(0, 32767)) % m;
    launch(x, longint'($urandom_range(0, 65535)), 16, m);
    wait_done("done_after_reset");

    // stray mult_done in IDLE, then doubled completions
    r0 = longint'(result); d0 = done_cnt;
    spur_req++;
    repeat (5) @(negedge clk);
    chk("spur_result", longint'(result), r0);
    chk("spur_busy", longint'(busy), 0);
    chk("spur_no_done", longint'(done_cnt - d0), 0);
    dbl_mode = 1;
    m = rand_mod(); x = longint'($urandom_range(0, 32767)) % m;
    e = longint'($urandom_range(0, 65535));
    launch(x, e, 16, m);
    wait_done("done_double");
    dbl_mode = 0;

    for (int i = 0; i < 6; i++) begin
      m = rand_mod(); x = longint'($urandom_range(0, 32767)) % m;
      e = longint'($urandom_range(0, 65535));
      launch(x, e, int'($urandom_range(1, 16)), m);
      wait_done("done_random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mont_exp_ctrl.md
Name: mont_exp_ctrl

Overview:
- Left-to-right square-and-multiply controller for modular exponentiation in the Montgomery domain.
- Sits directly upstream of the Montgomery multiplier core and drives its start/in_a/in_b/in_m. Consumes its result/done.
- Takes an operand already in Montgomery form (x·R mod M), R mod M, exponent, exponent length and modulus. Returns x^e mod M in normal form, including the final Mont(A,1) conversion.

Parameters:
- N, 1024, operand/modulus width in bits (R = 2^N).
- EW, 1024, exponent register width.
- LW, 11, width of exp_len; must satisfy 2^LW > EW.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- x_mont  input  N  x·R mod M
- r_mod_m  input  N  R mod M (Montgomery one)
- exponent  input  EW  exponent e; bits [exp_len-1:0] used
- exp_len  input  LW  number of exponent bits t, 0..EW
- modulus  input  N  M, odd, M < 2^(N-1)
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; result valid in the same cycle
- result  output  N  x^e mod M; held until the next accepted start
- mult_start  output  1  one-cycle start pulse to the multiplier
- mult_a  output  N  multiplier operand A
- mult_b  output  N  multiplier operand B
- mult_m  output  N  multiplier modulus; equals the latched M
- mult_result  input  N  multiplier product, valid while mult_done is high
- mult_done  input  1  multiplier one-cycle completion pulse

Behaviour:
- Reset values: busy=0, done=0, result=0, mult_start=0. State=IDLE. Internal regs A, X, E, M, bit index cleared.
- On start in IDLE, latch x_mont→X, r_mod_m→A, exponent→E, modulus→M, exp_len→idx. Go to LOAD. Inputs are ignored after this cycle.
- States and transitions:
  - IDLE: wait for start.
  - LOAD: if idx==0 go to POST_ISSUE, else go to SQR_ISSUE.
  - SQR_ISSUE: mult_a=A, mult_b=A, mult_start=1 for exactly this cycle. Go to SQR_WAIT.
  - SQR_WAIT: on mult_done, A←mult_result. If E[idx-1]==1 go to MUL_ISSUE, else go to NEXT.
  - MUL_ISSUE: mult_a=A, mult_b=X, mult_start=1. Go to MUL_WAIT.
  - MUL_WAIT: on mult_done, A←mult_result. Go to NEXT.
  - NEXT: idx←idx-1. If the decremented idx is 0 go to POST_ISSUE, else go to SQR_ISSUE.
  - POST_ISSUE: mult_a=A, mult_b=1 (zero-extended to N), mult_start=1. Go to POST_WAIT.
  - POST_WAIT: on mult_done, result←mult_result, done=1 next cycle. Go to DONE.
  - DONE: done=1 for one cycle, busy=0. Go to IDLE.
- mult_a, mult_b and mult_m must stay stable from the mult_start cycle until mult_done (the multiplier samples its operands throughout). Drive them from state-registered muxes, not transient logic.
- Multiplier latency is arbitrary (≥1 cycle). Wait states hold indefinitely. mult_done outside a WAIT state is ignored.
- Multiplication count = t + popcount(E[t-1:0]) + 1.
- Idle overhead per multiplication is ≤3 cycles (ISSUE, WAIT-capture, NEXT).
- start while busy is ignored: no re-latch, no effect on the running operation.
- reset mid-operation: next cycle state=IDLE, busy=0, mult_start=0, done=0. A multiplier already running is abandoned; its later mult_done is ignored in IDLE.
- exp_len > EW is undefined. The bench must not drive it.
- The multiplier's own resetn is driven externally as ~reset at top level. This block does not generate it.

Test Plan:
- N=16, M=13, x=5, x_mont=5·2^16 mod 13, r_mod_m=2^16 mod 13, e=3, t=2; behavioural Mont model with latency 7 → exactly 5 mult_start pulses, operand sequence (A,A),(A,X),(A,A),(A,X),(A,1), result=8, done single pulse.
- e=0, t=0, same M → single mult_start with mult_b=1, result=1.
- N=1024, random odd M, x, 1024-bit e with t=1024, real multiplier instance → result matches software pow(x,e,M). Mult count = 1025 + popcount(e).
- Mult model latency randomised 1..40 per op, t=8, e=0xA5 → result equals reference. mult_a/mult_b stable across every wait.
- start pulsed again during SQR_WAIT with different inputs → ignored, result for original inputs. Then reset asserted during the third wait → busy=0, mult_start=0 next cycle. A fresh start then completes correctly.
- Spurious mult_done in IDLE and a second mult_done in NEXT → no state change, result unchanged.
